// File: rtl/adc_fill_acq_ctrl.sv
// Acquisition controller: on trigger emits a header word, packed ADC sample bursts and a fill record.
// Optional feature OVR_FLAG_EN: lane bit 12 carries adc_ovr of that sample (otherwise 0).
module adc_fill_acq_ctrl #(
    parameter int SAMPLES_PER_BURST = 8
) (
    input  logic         adc_clk,
    input  logic         acq_reset,
    input  logic [11:0]  adc_data,
    input  logic         adc_ovr,
    input  logic [15:0]  channel_tag,
    input  logic [22:0]  muon_num_bursts,
    input  logic [22:0]  laser_num_bursts,
    input  logic [22:0]  ped_num_bursts,
    input  logic [23:0]  initial_fill_num,
    input  logic         initial_fill_num_wr,
    input  logic [11:0]  num_waveforms,
    input  logic [21:0]  waveform_gap,
    input  logic [22:0]  fixed_ddr3_start_addr,
    input  logic         en_fixed_ddr3_start_addr,
    input  logic         acq_enable0,
    input  logic         acq_enable1,
    input  logic         acq_trig,
    output logic         acq_enabled,
    output logic [23:0]  fill_num,
    output logic [127:0] adc_acq_out_dat,
    output logic         adc_acq_out_valid,
    output logic [22:0]  adc_acq_out_addr,
    output logic         acq_done,
    output logic [151:0] fill_header_out,
    output logic         fill_header_valid
);

    localparam logic [2:0] LAST_LANE = 3'(SAMPLES_PER_BURST - 1);

    typedef enum logic [2:0] {IDLE, HEADER, CAPTURE, GAP, DONE} state_t;

    state_t        state;
    logic          trig_p0;
    logic [1:0]    fill_type;
    logic [22:0]   num_bursts;
    logic [11:0]   num_wf;
    logic [22:0]   start_addr;
    logic [22:0]   word_addr;
    logic [22:0]   next_addr;
    logic [2:0]    lane_idx;
    logic [22:0]   burst_cnt;
    logic [11:0]   wf_cnt;
    logic [21:0]   gap_cnt;
    logic [23:0]   word_total;
    logic [111:0]  lanes_p0;

    logic [1:0]    type_in;
    logic [22:0]   bursts_in;
    logic [11:0]   wf_in;
    logic [22:0]   start_in;
    logic          trig_edge;
    logic          ovr_bit;
    logic [15:0]   sample;

`ifdef OVR_FLAG_EN
    assign ovr_bit = adc_ovr;
`else
    logic unused_ovr;
    assign unused_ovr = adc_ovr;
    assign ovr_bit    = 1'b0;
`endif

    assign type_in   = {acq_enable1, acq_enable0};
    assign trig_edge = acq_trig & ~trig_p0;
    assign wf_in     = (num_waveforms == 12'd0) ? 12'd1 : num_waveforms;
    assign start_in  = en_fixed_ddr3_start_addr ? fixed_ddr3_start_addr : next_addr;
    assign sample    = {3'b000, ovr_bit, adc_data};

    always_comb begin
        bursts_in = muon_num_bursts;
        case (type_in)
            2'b10:   bursts_in = laser_num_bursts;
            2'b11:   bursts_in = ped_num_bursts;
            default: bursts_in = muon_num_bursts;
        endcase
    end

    // Lanes 0..6 of the current burst; lane 7 is taken straight from the input when the word is built.
    always_ff @(posedge adc_clk) begin
        if (state == CAPTURE && lane_idx != LAST_LANE)
            lanes_p0[{lane_idx, 4'b0000} +: 16] <= sample;
    end

    always_ff @(posedge adc_clk or posedge acq_reset) begin
        if (acq_reset) begin
            state             <= IDLE;
            trig_p0           <= 1'b0;
            acq_enabled       <= 1'b0;
            fill_num          <= '0;
            next_addr         <= '0;
            adc_acq_out_dat   <= '0;
            adc_acq_out_valid <= 1'b0;
            adc_acq_out_addr  <= '0;
            acq_done          <= 1'b0;
            fill_header_out   <= '0;
            fill_header_valid <= 1'b0;
            fill_type         <= '0;
            num_bursts        <= '0;
            num_wf            <= '0;
            start_addr        <= '0;
            word_addr         <= '0;
            lane_idx          <= '0;
            burst_cnt         <= '0;
            wf_cnt            <= '0;
            gap_cnt           <= '0;
            word_total        <= '0;
        end else begin
            trig_p0           <= acq_trig;
            acq_enabled       <= (type_in != 2'b00);
            adc_acq_out_valid <= 1'b0;
            acq_done          <= 1'b0;
            fill_header_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (initial_fill_num_wr)
                        fill_num <= initial_fill_num;
                    if (trig_edge && type_in != 2'b00) begin
                        fill_type         <= type_in;
                        num_bursts        <= bursts_in;
                        num_wf            <= wf_in;
                        start_addr        <= start_in;
                        adc_acq_out_dat   <= {fill_num, channel_tag, type_in, bursts_in,
                                              start_in, wf_in, 28'd0};
                        adc_acq_out_valid <= 1'b1;
                        adc_acq_out_addr  <= start_in;
                        word_addr         <= start_in + 23'd1;
                        word_total        <= 24'd1;
                        lane_idx          <= '0;
                        burst_cnt         <= '0;
                        wf_cnt            <= '0;
                        state             <= HEADER;
                    end
                end
                HEADER: state <= (num_bursts == 23'd0) ? DONE : CAPTURE;
                CAPTURE: begin
                    lane_idx <= lane_idx + 3'd1;
                    if (lane_idx == LAST_LANE) begin
                        adc_acq_out_dat   <= {sample, lanes_p0};
                        adc_acq_out_valid <= 1'b1;
                        adc_acq_out_addr  <= word_addr;
                        word_addr         <= word_addr + 23'd1;
                        word_total        <= word_total + 24'd1;
                        if (burst_cnt == num_bursts - 23'd1) begin
                            burst_cnt <= '0;
                            if (wf_cnt == num_wf - 12'd1) begin
                                state <= DONE;
                            end else begin
                                wf_cnt <= wf_cnt + 12'd1;
                                // zero gap keeps capturing back-to-back
                                if (waveform_gap != 22'd0) begin
                                    gap_cnt <= waveform_gap - 22'd1;
                                    state   <= GAP;
                                end
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 23'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 22'd0)
                        state <= CAPTURE;
                    else
                        gap_cnt <= gap_cnt - 22'd1;
                end
                DONE: begin
                    acq_done          <= 1'b1;
                    fill_header_valid <= 1'b1;
                    fill_header_out   <= {fill_num, channel_tag, fill_type, 10'd0,
                                          word_total, start_addr, 53'd0};
                    fill_num          <= fill_num + 24'd1;
                    next_addr         <= word_addr;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_fill_acq_ctrl.sv
// Bench for adc_fill_acq_ctrl: timeline model of each fill plus directed literal checks.
module tb_adc_fill_acq_ctrl;

    logic         adc_clk = 1'b0;
    logic         acq_reset = 1'b1;
    logic [11:0]  adc_data = '0;
    logic         adc_ovr = 1'b0;
    logic [15:0]  channel_tag = '0;
    logic [22:0]  muon_num_bursts = '0;
    logic [22:0]  laser_num_bursts = '0;
    logic [22:0]  ped_num_bursts = '0;
    logic [23:0]  initial_fill_num = '0;
    logic         initial_fill_num_wr = 1'b0;
    logic [11:0]  num_waveforms = '0;
    logic [21:0]  waveform_gap = '0;
    logic [22:0]  fixed_ddr3_start_addr = '0;
    logic         en_fixed_ddr3_start_addr = 1'b0;
    logic         acq_enable0 = 1'b0;
    logic         acq_enable1 = 1'b0;
    logic         acq_trig = 1'b0;
    logic         acq_enabled;
    logic [23:0]  fill_num;
    logic [127:0] adc_acq_out_dat;
    logic         adc_acq_out_valid;
    logic [22:0]  adc_acq_out_addr;
    logic         acq_done;
    logic [151:0] fill_header_out;
    logic         fill_header_valid;

    adc_fill_acq_ctrl dut (
        .adc_clk(adc_clk), .acq_reset(acq_reset), .adc_data(adc_data), .adc_ovr(adc_ovr),
        .channel_tag(channel_tag), .muon_num_bursts(muon_num_bursts),
        .laser_num_bursts(laser_num_bursts), .ped_num_bursts(ped_num_bursts),
        .initial_fill_num(initial_fill_num), .initial_fill_num_wr(initial_fill_num_wr),
        .num_waveforms(num_waveforms), .waveform_gap(waveform_gap),
        .fixed_ddr3_start_addr(fixed_ddr3_start_addr),
        .en_fixed_ddr3_start_addr(en_fixed_ddr3_start_addr),
        .acq_enable0(acq_enable0), .acq_enable1(acq_enable1), .acq_trig(acq_trig),
        .acq_enabled(acq_enabled), .fill_num(fill_num), .adc_acq_out_dat(adc_acq_out_dat),
        .adc_acq_out_valid(adc_acq_out_valid), .adc_acq_out_addr(adc_acq_out_addr),
        .acq_done(acq_done), .fill_header_out(fill_header_out),
        .fill_header_valid(fill_header_valid)
    );

    always #5 adc_clk = ~adc_clk;

    int n_checks = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int ramp_off = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample at edge k is (k - ramp_off); the stimulus moves ramp_off so a fill's first sample is 0.
    always @(posedge adc_clk) begin
        #2;
        adc_data = 12'(edge_cnt + 1 - ramp_off);
        adc_ovr  = 1'((edge_cnt + 1) >> 2);
    end

    // Model: at an accepted trigger, lay out the whole fill on the edge timeline.
    logic [15:0]  samp     [int];
    int           exp_kind [int];
    logic [127:0] exp_hdr  [int];
    logic [22:0]  exp_addr [int];
    logic [151:0] exp_rec  [int];
    bit           m_busy = 0;
    int           m_done_edge = 0;
    logic [23:0]  m_fill = '0;
    logic [22:0]  m_next = '0;
    logic [22:0]  m_next_after = '0;
    bit           m_trig_prev = 0;
    logic         m_en = 1'b0;

    always @(posedge adc_clk) begin
        int k, nb, nw, gp, n, e, last;
        bit idle, ovr_m;
        logic [1:0] ty;
        logic [22:0] st;
        edge_cnt++;
        k = edge_cnt;
        if (acq_reset) begin
            m_busy = 0; m_fill = '0; m_next = '0; m_trig_prev = 0; m_en = 1'b0;
            exp_kind.delete(); exp_hdr.delete(); exp_addr.delete(); exp_rec.delete();
        end else begin
`ifdef OVR_FLAG_EN
            ovr_m = adc_ovr;
`else
            ovr_m = 1'b0;
`endif
            samp[k] = {3'b000, ovr_m, adc_data};
            m_en = acq_enable0 | acq_enable1;
            idle = !m_busy;
            if (m_busy && k == m_done_edge) begin
                m_fill = m_fill + 24'd1;
                m_next = m_next_after;
                m_busy = 0;
            end
            ty = {acq_enable1, acq_enable0};
            if (idle && acq_trig && !m_trig_prev && ty != 2'b00) begin
                nb = (ty == 2'b01) ? int'(muon_num_bursts) :
                     (ty == 2'b10) ? int'(laser_num_bursts) : int'(ped_num_bursts);
                nw = (num_waveforms == 0) ? 1 : int'(num_waveforms);
                gp = int'(waveform_gap);
                st = en_fixed_ddr3_start_addr ? fixed_ddr3_start_addr : m_next;
                exp_kind[k] = 1;
                exp_hdr[k]  = {m_fill, channel_tag, ty, 23'(nb), st, 12'(nw), 28'd0};
                exp_addr[k] = st;
                n = 0;
                for (int w = 0; w < nw; w++)
                    for (int b = 0; b < nb; b++) begin
                        e = k + 1 + w * (8 * nb + gp) + 8 * (b + 1);
                        n++;
                        exp_kind[e] = 2;
                        exp_addr[e] = 23'(st + 23'(n));
                    end
                last = (nb == 0) ? k + 1 : k + 1 + nw * 8 * nb + (nw - 1) * gp;
                exp_rec[last + 1] = {m_fill, channel_tag, ty, 10'd0, 24'(n + 1), st, 53'd0};
                m_done_edge  = last + 1;
                m_next_after = 23'(st + 23'(n + 1));
                m_busy = 1;
            end
            if (idle && initial_fill_num_wr)
                m_fill = initial_fill_num;
            m_trig_prev = acq_trig;
        end
    end

    logic [127:0] word_q[$];
    logic [22:0]  addr_q[$];
    logic [151:0] rec_q[$];

    // Compare process plus output log for the directed checks.
    always @(negedge adc_clk) begin
        logic [127:0] ew;
        int k;
        k = edge_cnt;
        if (acq_reset) begin
            chk("reset_ctrl", {adc_acq_out_valid, acq_done, fill_header_valid, acq_enabled,
                               fill_num, adc_acq_out_addr}, '0);
            chk("reset_dat", adc_acq_out_dat, '0);
            chk("reset_rec", fill_header_out, '0);
        end else if (k > 0) begin
            chk("out_valid", adc_acq_out_valid, exp_kind.exists(k));
            if (exp_kind.exists(k)) begin
                if (exp_kind[k] == 1) ew = exp_hdr[k];
                else for (int i = 0; i < 8; i++) ew[16*i +: 16] = samp[k - 7 + i];
                chk("out_dat", adc_acq_out_dat, ew);
                chk("out_addr", adc_acq_out_addr, exp_addr[k]);
            end
            chk("done", {acq_done, fill_header_valid}, exp_rec.exists(k) ? 2'b11 : 2'b00);
            if (exp_rec.exists(k)) chk("fill_rec", fill_header_out, exp_rec[k]);
            chk("fill_num", fill_num, m_fill);
            chk("acq_enabled", acq_enabled, m_en);
            if (adc_acq_out_valid) begin
                word_q.push_back(adc_acq_out_dat);
                addr_q.push_back(adc_acq_out_addr);
            end
            if (acq_done) begin
                rec_q.push_back(fill_header_out);
                done_cnt++;
            end
        end
    end

    task automatic tick;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic clear_logs;
        word_q.delete(); addr_q.delete(); rec_q.delete();
    endtask

    task automatic fire_trig;
        acq_trig = 1'b1;
        ramp_off = edge_cnt + 3;
        tick();
        acq_trig = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chk("done_in_time", done_cnt > d0, 1'b1);
    endtask

    function automatic logic [127:0] wq(input int i);
        return (i < word_q.size()) ? word_q[i] : '0;
    endfunction

    function automatic logic [22:0] aq(input int i);
        return (i < addr_q.size()) ? addr_q[i] : '0;
    endfunction

    function automatic logic [151:0] rq(input int i);
        return (i < rec_q.size()) ? rec_q[i] : '0;
    endfunction

    initial begin
        repeat (3) tick();
        chk("rst_all_out", {adc_acq_out_valid, acq_done, fill_header_valid, acq_enabled,
                            fill_num, adc_acq_out_addr}, '0);
        acq_reset = 1'b0;
        tick();
        initial_fill_num = 24'h55; initial_fill_num_wr = 1'b1;
        tick();
        initial_fill_num_wr = 1'b0;
        chk("preload", fill_num, 24'h55);

        // First MUON fill: header + 2 ramp words
        muon_num_bursts = 23'd2; num_waveforms = 12'd1; channel_tag = 16'h0008; acq_enable0 = 1'b1;
        tick();
        clear_logs();
        fire_trig();
        wait_done(100);
        chk("f1_words", word_q.size(), 3);
        chk("f1_addrs", {aq(0), aq(1), aq(2)}, {23'd0, 23'd1, 23'd2});
        chk("f1_hdr_fill", wq(0)[127:104], 24'h55);
        chk("f1_hdr_tag", wq(0)[103:88], 16'h0008);
        chk("f1_hdr_type", wq(0)[87:86], 2'b01);
        for (int i = 0; i < 8; i++) begin
            logic [127:0] w1;
            w1 = wq(1);
            chk($sformatf("ramp_lane%0d", i), {w1[16*i+15 -: 3], w1[16*i +: 12]}, 15'(i));
        end
        chk("f1_rec_start", rq(0)[75:53], 23'd0);
        chk("f1_rec_total", rq(0)[99:76], 24'd3);
        chk("f1_fill_inc", fill_num, 24'h56);

        // Second fill continues at the next address
        tick();
        clear_logs();
        fire_trig();
        wait_done(100);
        chk("f2_start", aq(0), 23'd3);
        chk("f2_hdr_fill", wq(0)[127:104], 24'h56);
        chk("f2_last_addr", aq(2), 23'd5);

        // Fixed start address wrapping past the top
        en_fixed_ddr3_start_addr = 1'b1; fixed_ddr3_start_addr = 23'h7FFFFE;
        tick();
        clear_logs();
        fire_trig();
        wait_done(100);
        chk("wrap_addrs", {aq(0), aq(1), aq(2)}, {23'h7FFFFE, 23'h7FFFFF, 23'h000000});
        en_fixed_ddr3_start_addr = 1'b0;

        // Two waveforms with gap 5, plus an ignored trigger mid-fill
        num_waveforms = 12'd2; waveform_gap = 22'd5; muon_num_bursts = 23'd1;
        tick();
        clear_logs();
        fire_trig();
        repeat (4) tick();
        acq_trig = 1'b1;
        tick();
        acq_trig = 1'b0;
        wait_done(100);
        repeat (20) tick();
        chk("gap_words", word_q.size(), 3);
        chk("gap_rec_total", rq(0)[99:76], 24'd3);
        chk("gap_w0_lane7", wq(1)[123:112], 12'd7);
        chk("gap_w1_lane0", wq(2)[11:0], 12'd13);
        chk("gap_one_record", rec_q.size(), 1);

        // LASER, num_waveforms 0 -> 1, enables cleared mid-fill
        num_waveforms = 12'd0; waveform_gap = 22'd0; laser_num_bursts = 23'd1;
        acq_enable0 = 1'b0; acq_enable1 = 1'b1;
        tick();
        clear_logs();
        fire_trig();
        repeat (3) tick();
        acq_enable1 = 1'b0;
        wait_done(100);
        chk("laser_words", word_q.size(), 2);
        chk("laser_hdr", {wq(0)[87:86], wq(0)[85:63], wq(0)[39:28]}, {2'b10, 23'd1, 12'd1});
        chk("laser_rec_type", rq(0)[111:110], 2'b10);

        // PEDESTAL with zero bursts: header only
        ped_num_bursts = 23'd0; acq_enable0 = 1'b1; acq_enable1 = 1'b1;
        tick();
        clear_logs();
        fire_trig();
        wait_done(100);
        chk("ped_words", word_q.size(), 1);
        chk("ped_rec", {rq(0)[111:110], rq(0)[99:76]}, {2'b11, 24'd1});

        // Disabled type: trigger ignored
        acq_enable0 = 1'b0; acq_enable1 = 1'b0;
        tick();
        clear_logs();
        fire_trig();
        repeat (40) tick();
        chk("disabled_no_fill", {word_q.size(), rec_q.size()}, 64'd0);

        // Reset mid-fill: no record, counters back to zero
        acq_enable0 = 1'b1; muon_num_bursts = 23'd2; num_waveforms = 12'd1;
        tick();
        clear_logs();
        fire_trig();
        repeat (5) tick();
        acq_reset = 1'b1;
        #1;
        chk("midrst_out", {adc_acq_out_valid, acq_done, fill_num}, '0);
        tick();
        acq_reset = 1'b0;
        repeat (30) tick();
        chk("midrst_no_rec", rec_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_fill_acq_ctrl.md
Name: adc_fill_acq_ctrl

Overview:
- Single-clock acquisition controller between the deserialized ADC sample stream and the DDR3 write path.
- On a trigger it emits one 128-bit header word, then packed ADC sample bursts (8 samples per 128-bit word) for N waveforms separated by a programmable gap.
- Every emitted word gets a DDR3 burst address. At end of fill it emits a 152-bit fill-header record, consumed by the readout logic to locate the fill.

Parameters:
- SAMPLES_PER_BURST, 8, samples packed per 128-bit word; 16 bits per lane; fixed at 8.

Ports:
- adc_clk  in  1  sole clock, rising edge
- acq_reset  in  1  asynchronous, active-high reset
- adc_data  in  12  ADC sample, one per clock
- adc_ovr  in  1  ADC over-range flag for adc_data
- channel_tag  in  16  channel identifier placed in the header
- muon_num_bursts  in  23  bursts per waveform, fill type MUON
- laser_num_bursts  in  23  bursts per waveform, fill type LASER
- ped_num_bursts  in  23  bursts per waveform, fill type PEDESTAL
- initial_fill_num  in  24  fill-number preload value
- initial_fill_num_wr  in  1  preload strobe
- num_waveforms  in  12  waveforms per trigger; 0 treated as 1
- waveform_gap  in  22  idle clocks between waveforms
- fixed_ddr3_start_addr  in  23  fixed fill start address
- en_fixed_ddr3_start_addr  in  1  use fixed_ddr3_start_addr for every fill
- acq_enable0, acq_enable1  in  1 each  fill type / enable
- acq_trig  in  1  trigger; level input, rising edge used
- acq_enabled  out  1  {acq_enable1,acq_enable0} != 0, registered
- fill_num  out  24  current fill number
- adc_acq_out_dat  out  128  header or sample word
- adc_acq_out_valid  out  1  word valid, one-clock strobe per word
- adc_acq_out_addr  out  23  DDR3 burst address of the current word
- acq_done  out  1  one-clock pulse at end of fill
- fill_header_out  out  152  fill record
- fill_header_valid  out  1  one-clock strobe with acq_done

Behaviour:
- Reset values:
  - all outputs 0
  - fill_num 0
  - next_addr 0
  - state IDLE
  - trigger edge register 0
- Fill type from {acq_enable1,acq_enable0}: 01 MUON, 10 LASER, 11 PEDESTAL, 00 disabled. The type and its num_bursts are latched at trigger.
- initial_fill_num_wr high in IDLE: fill_num <= initial_fill_num next edge. Ignored outside IDLE.
- Trigger is a registered rising edge of acq_trig, accepted only in IDLE with type != 00. Edges during a fill are ignored and are not queued.
- States: IDLE -> HEADER -> CAPTURE -> (GAP -> CAPTURE)* -> DONE -> IDLE.
- Start address: start = en_fixed_ddr3_start_addr ? fixed_ddr3_start_addr : next_addr, latched at trigger.
- HEADER (one clock after the accepting edge):
  - adc_acq_out_valid=1, adc_acq_out_addr=start.
  - Header word: [127:104] fill_num, [103:88] channel_tag, [87:86] type, [85:63] num_bursts, [62:40] start, [39:28] effective num_waveforms, [27:0] 0.
- Address rule: each subsequent word gets address+1, wrapping mod 2^23.
- CAPTURE:
  - Sample i of a burst goes to lane i, bits [16i+15:16i] = {3'b0, ovr_bit, adc_data}; lane 0 is the earliest sample.
  - The word is valid the clock after its 8th sample.
  - After num_bursts words the waveform ends. num_bursts=0 produces no sample words.
- GAP: waveform_gap idle clocks, entered only between waveforms. A gap of 0 gives back-to-back capture.
- DONE (one clock):
  - acq_done=1, fill_header_valid=1.
  - fill_header_out: [151:128] fill_num, [127:112] channel_tag, [111:110] type, [109:100] 0, [99:76] total words written including header (24b), [75:53] start, [52:0] 0.
  - Next edge: fill_num+1 (wraps at 2^24); next_addr = last address+1.
- Clearing the enables mid-fill does not abort the fill; it completes normally.
- acq_reset mid-fill returns to IDLE immediately. Output valids drop and no record is emitted.

Optional Feature:
- OVR_FLAG_EN defined: lane bit 12 = adc_ovr of that sample.
- Not defined: lane bit 12 = 0; adc_ovr is unused.

Test Plan:
- Reset with acq_reset=1: all outputs 0. Release reset, write initial_fill_num=0x55 with the strobe: fill_num=0x55.
- muon_num_bursts=2, num_waveforms=1, channel_tag=0x0008, acq_enable0=1, pulse acq_trig:
  - 3 valid words at addresses 0, 1, 2
  - header [127:104]=0x55, [103:88]=0x0008, [87:86]=01
  - record [75:53]=0, [99:76]=3
  - fill_num becomes 0x56
- Second trigger afterwards: start address 3; header fill_num=0x56.
- Ramp adc_data 0,1,2,...: lanes in the first data word hold 0..7 in lane order.
- en_fixed_ddr3_start_addr=1, fixed=0x7FFFFE, 2 bursts: addresses 0x7FFFFE, 0x7FFFFF, 0x000000 (wrap).
- num_waveforms=2, waveform_gap=5, 1 burst: exactly 5 idle clocks between the two data words; record total=3. A trigger during the fill is ignored.
